// File: rtl/basic_pkg.sv
// rtl/basic_pkg.sv - shared constants and helpers for the basic FIFO slice
package basic_pkg;

  localparam logic RST_ACTIVE = 1'b1;
  localparam int   DW_DEFAULT = 32;
  localparam int   AW_DEFAULT = 2;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/basic_fifo_ptr.sv
// rtl/basic_fifo_ptr.sv - wrapping pointer register with increment enable
module basic_fifo_ptr
  import basic_pkg::*;
#(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // The extra MSB beyond the address bits lets full and empty be told apart.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + W'(1);
    end
  end

endmodule

// File: rtl/basic_fifo.sv
// rtl/basic_fifo.sv - first-word-fall-through valid/ready FIFO ahead of the register stage
module basic_fifo
  import basic_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          push;
  logic          pop;

  // Flags come only from registered pointers, so no handshake input feeds them.
  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count      = wr_ptr - rd_ptr;
  assign din_ready  = !full;
  assign dout_valid = !empty;
  assign dout       = empty ? '0 : mem[rd_ptr[AW-1:0]];

  assign push = din_valid && din_ready;
  assign pop  = dout_valid && dout_ready;

  always_ff @(posedge CLK) begin
    if (push && (RST != RST_ACTIVE)) begin
      mem[wr_ptr[AW-1:0]] <= din;
    end
  end

  basic_fifo_ptr #(.W(AW + 1)) u_wr_ptr (
    .clk (CLK),
    .rst (RST),
    .inc (push),
    .ptr (wr_ptr)
  );

  basic_fifo_ptr #(.W(AW + 1)) u_rd_ptr (
    .clk (CLK),
    .rst (RST),
    .inc (pop),
    .ptr (rd_ptr)
  );

endmodule

// File: tb/tb_basic_fifo.sv
// tb/tb_basic_fifo.sv - directed and randomized checks of basic_fifo against a queue model
module tb_basic_fifo;

  localparam int DW    = 32;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk;
  logic          RST;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [AW:0]   count;
  logic          full;
  logic          empty;

  int n_checks;
  int n_fail;
  logic [DW-1:0] model_q[$];

  basic_fifo #(.DW(DW), .AW(AW)) dut (
    .CLK        (clk),
    .RST        (RST),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state(input string tag);
    int sz;
    sz = model_q.size();
    check({tag, ".count"}, 32'(count), 32'(sz));
    check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
    check({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
    check({tag, ".din_ready"}, 32'(din_ready), 32'(sz != DEPTH));
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(sz != 0));
    check({tag, ".dout"}, dout, (sz != 0) ? model_q[0] : 32'h0);
  endtask

  // Inputs are applied mid-cycle; the model advances at the edge from its pre-edge occupancy.
  task automatic cycle(input string tag, input logic r, input logic dv,
                       input logic [DW-1:0] d, input logic dr);
    int  sz;
    bit  do_pop;
    bit  do_push;
    RST        = r;
    din_valid  = dv;
    din        = d;
    dout_ready = dr;
    @(posedge clk);
    sz = model_q.size();
    if (r) begin
      model_q.delete();
    end else begin
      do_pop  = (sz > 0) && dr;
      do_push = (sz < DEPTH) && dv;
      if (do_pop) void'(model_q.pop_front());
      if (do_push) model_q.push_back(d);
    end
    @(negedge clk);
    check_state(tag);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b0;

    cycle("reset0", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    cycle("reset1", 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    cycle("idle", 1'b0, 1'b0, 32'h0, 1'b0);

    for (int i = 1; i <= 4; i++) cycle("fill", 1'b0, 1'b1, 32'(i), 1'b0);
    cycle("fill_over", 1'b0, 1'b1, 32'h5, 1'b0);
    check("fill_over.count4", 32'(count), 32'd4);

    for (int i = 0; i < 5; i++) cycle("drain", 1'b0, 1'b0, 32'h0, 1'b1);
    check("drain.dout_zero", dout, 32'h0);

    for (int i = 5; i <= 10; i++) begin
      cycle("wrap_push", 1'b0, 1'b1, 32'(i), 1'b0);
      if (i % 2 == 0) cycle("wrap_pop", 1'b0, 1'b0, 32'h0, 1'b1);
    end
    for (int i = 0; i < 4; i++) cycle("wrap_drain", 1'b0, 1'b0, 32'h0, 1'b1);

    cycle("sim_pre", 1'b0, 1'b1, 32'h11, 1'b0);
    cycle("sim_pre", 1'b0, 1'b1, 32'h22, 1'b0);
    for (int i = 0; i < 6; i++) begin
      cycle("simul", 1'b0, 1'b1, 32'hA0 + 32'(i), 1'b1);
      check("simul.count2", 32'(count), 32'd2);
    end

    cycle("to_full", 1'b0, 1'b1, 32'hB0, 1'b0);
    cycle("to_full", 1'b0, 1'b1, 32'hB1, 1'b0);
    check("to_full.full", 32'(full), 32'd1);
    cycle("full_both", 1'b0, 1'b1, 32'hC0, 1'b1);
    check("full_both.count3", 32'(count), 32'd3);
    check("full_both.din_ready", 32'(din_ready), 32'd1);
    cycle("full_hold", 1'b0, 1'b1, 32'hC0, 1'b0);

    for (int i = 0; i < 4; i++) cycle("to_empty", 1'b0, 1'b0, 32'h0, 1'b1);
    cycle("empty_both", 1'b0, 1'b1, 32'h55, 1'b1);
    check("empty_both.dout_valid", 32'(dout_valid), 32'd1);
    check("empty_both.dout", dout, 32'h55);

    cycle("pre_rst", 1'b0, 1'b1, 32'h61, 1'b0);
    cycle("pre_rst", 1'b0, 1'b1, 32'h62, 1'b0);
    cycle("mid_rst", 1'b1, 1'b1, 32'h63, 1'b1);
    check("mid_rst.count0", 32'(count), 32'd0);
    cycle("post_rst", 1'b0, 1'b1, 32'h77, 1'b0);
    check("post_rst.dout77", dout, 32'h77);

    for (int i = 0; i < 400; i++) begin
      cycle("rand", ($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
            $urandom, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
